// File: rtl/pong_game_controller.sv
// Pong match controller: scores, BCD countdown clock, idle/serve/rally/game-over sequencing.
// Optional PONG_PAUSE_EN adds a PAUSE state toggled by start during a rally.
module pong_game_controller #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int GAME_SECONDS = 60,
   parameter int WIN_SCORE    = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       miss1,
   input  logic       miss2,
   output logic       stop,
   output logic [3:0] sec1,
   output logic [3:0] sec0,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic [1:0] winner,
`ifdef PONG_PAUSE_EN
   output logic [2:0] state_o
`else
   output logic [1:0] state_o
`endif
);

   localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
   localparam logic [3:0]    SEC1_INIT  = 4'(GAME_SECONDS / 10);
   localparam logic [3:0]    SEC0_INIT  = 4'(GAME_SECONDS % 10);
   localparam logic [3:0]    WIN_PTS    = 4'(WIN_SCORE);

`ifdef PONG_PAUSE_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_PAUSE = 3'd3, S_OVER = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3
   } state_t;
`endif

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    sec1_q, sec1_d, sec0_q, sec0_d;
   logic [3:0]    score1_q, score1_d, score2_q, score2_d;
   logic [1:0]    winner_q, winner_d;
   logic          stop_q, stop_d;
   logic          start_q;
   logic          start_rise, tick, rally_step, new_match, end_match;

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s == 4'd15) ? s : s + 4'd1;
   endfunction

   assign start_rise = start & ~start_q;
   assign tick       = (presc_q == PRESC_LAST);

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      sec1_d     = sec1_q;
      sec0_d     = sec0_q;
      score1_d   = score1_q;
      score2_d   = score2_q;
      winner_d   = winner_q;
      rally_step = 1'b0;
      new_match  = 1'b0;
      end_match  = 1'b0;

      case (state_q)
         S_IDLE:  if (start_rise) new_match = 1'b1;
         S_SERVE: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) state_d = S_PLAY;
         end
         S_PLAY: begin
`ifdef PONG_PAUSE_EN
            if (start_rise) state_d = S_PAUSE;
            else            rally_step = 1'b1;
`else
            rally_step = 1'b1;
`endif
         end
`ifdef PONG_PAUSE_EN
         S_PAUSE: if (start_rise) state_d = S_PLAY;
`endif
         S_OVER:  if (start_rise) new_match = 1'b1;
         default: state_d = S_IDLE;
      endcase

      // A miss and a tick in the same cycle both land; OVER beats SERVE.
      if (rally_step) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (miss1) begin
            score2_d = sat_inc(score2_q);
            state_d  = S_SERVE;
            presc_d  = '0;
            if (score2_d == WIN_PTS) end_match = 1'b1;
         end else if (miss2) begin
            score1_d = sat_inc(score1_q);
            state_d  = S_SERVE;
            presc_d  = '0;
            if (score1_d == WIN_PTS) end_match = 1'b1;
         end
         if (tick) begin
            if (sec0_q == 4'd0) begin
               sec0_d = 4'd9;
               sec1_d = sec1_q - 4'd1;
            end else begin
               sec0_d = sec0_q - 4'd1;
            end
            if (sec1_q == 4'd0 && sec0_q == 4'd1) end_match = 1'b1;
         end
         if (end_match) begin
            state_d = S_OVER;
            if (score1_d > score2_d)      winner_d = 2'b01;
            else if (score2_d > score1_d) winner_d = 2'b10;
            else                          winner_d = 2'b11;
         end
      end

      if (new_match) begin
         state_d  = S_SERVE;
         presc_d  = '0;
         sec1_d   = SEC1_INIT;
         sec0_d   = SEC0_INIT;
         score1_d = 4'd0;
         score2_d = 4'd0;
         winner_d = 2'b00;
      end

      stop_d = (state_d != S_PLAY);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         presc_q  <= '0;
         sec1_q   <= SEC1_INIT;
         sec0_q   <= SEC0_INIT;
         score1_q <= 4'd0;
         score2_q <= 4'd0;
         winner_q <= 2'b00;
         stop_q   <= 1'b1;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         sec1_q   <= sec1_d;
         sec0_q   <= sec0_d;
         score1_q <= score1_d;
         score2_q <= score2_d;
         winner_q <= winner_d;
         stop_q   <= stop_d;
         start_q  <= start;
      end
   end

   assign stop    = stop_q;
   assign sec1    = sec1_q;
   assign sec0    = sec0_q;
   assign score1  = score1_q;
   assign score2  = score2_q;
   assign winner  = winner_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Bench for pong_game_controller: directed match scenarios then random play,
// every cycle compared against an integer-seconds reference model.
module tb_pong_game_controller;

   localparam int CLK_HZ = 10;
   localparam int GAME   = 12;
   localparam int WIN    = 3;
`ifdef PONG_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
   localparam int ST_OVER  = 4;
   logic [2:0] state_o;
`else
   localparam bit PAUSE_EN = 1'b0;
   localparam int ST_OVER  = 3;
   logic [1:0] state_o;
`endif
   localparam int ST_PAUSE = 3;

   logic clk = 1'b0;
   logic rst, start, miss1, miss2, stop;
   logic [3:0] sec1, sec0, score1, score2;
   logic [1:0] winner;

   int n_tot = 0;
   int n_pass = 0;

   int m_state, m_cnt, m_rem, m_s1, m_s2, m_win;
   bit m_prev;

   pong_game_controller #(.CLK_HZ(CLK_HZ), .GAME_SECONDS(GAME), .WIN_SCORE(WIN)) dut (
      .clk(clk), .rst(rst), .start(start), .miss1(miss1), .miss2(miss2),
      .stop(stop), .sec1(sec1), .sec0(sec0), .score1(score1), .score2(score2),
      .winner(winner), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_rem = GAME;
      m_s1 = 0; m_s2 = 0; m_win = 0; m_prev = 1'b0;
   endtask

   // Match rules in plain integers: remaining whole seconds, elapsed cycles.
   task automatic model_step(input bit st, input bit m1, input bit m2);
      bit rise, over, sec_done;
      rise   = st && !m_prev;
      m_prev = st;
      if ((m_state == 0 || m_state == ST_OVER) && rise) begin
         m_state = 1; m_cnt = 0; m_rem = GAME; m_s1 = 0; m_s2 = 0; m_win = 0;
      end else if (m_state == 1) begin
         m_cnt++;
         if (m_cnt == CLK_HZ) begin m_state = 2; m_cnt = 0; end
      end else if (m_state == 2) begin
         if (PAUSE_EN && rise) begin
            m_state = ST_PAUSE;
         end else begin
            m_cnt++;
            sec_done = (m_cnt == CLK_HZ);
            if (sec_done) m_cnt = 0;
            over = 1'b0;
            if (m1) begin
               m_s2 = (m_s2 >= 15) ? 15 : m_s2 + 1;
               m_state = 1; m_cnt = 0; over = (m_s2 == WIN);
            end else if (m2) begin
               m_s1 = (m_s1 >= 15) ? 15 : m_s1 + 1;
               m_state = 1; m_cnt = 0; over = (m_s1 == WIN);
            end
            if (sec_done) begin
               m_rem--;
               if (m_rem == 0) over = 1'b1;
            end
            if (over) begin
               m_state = ST_OVER;
               m_win = (m_s1 > m_s2) ? 1 : ((m_s2 > m_s1) ? 2 : 3);
            end
         end
      end else if (PAUSE_EN && m_state == ST_PAUSE && rise) begin
         m_state = 2;
      end
   endtask

   function automatic logic [31:0] exp_vec();
      return {10'b0, 3'(m_state), (m_state != 2), 4'(m_rem / 10), 4'(m_rem % 10),
              4'(m_s1), 4'(m_s2), 2'(m_win)};
   endfunction

   function automatic logic [31:0] dut_vec();
      return {10'b0, 3'(state_o), stop, sec1, sec0, score1, score2, winner};
   endfunction

   task automatic cyc(input bit st, input bit m1, input bit m2);
      start = st; miss1 = m1; miss2 = m2;
      @(posedge clk);
      model_step(st, m1, m2);
      #1;
      chk("cycle", dut_vec(), exp_vec());
   endtask

   task automatic wait_state(input int target, input int budget, output int n);
      n = 0;
      while (32'(state_o) != 32'(target) && n < budget) begin
         cyc(1'b0, 1'b0, 1'b0);
         n++;
      end
      chk("wait_state", 32'(state_o), 32'(target));
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
      model_reset();
      #12;
      chk("rst_state", 32'(state_o), 0);
      chk("rst_stop", 32'(stop), 1);
      chk("rst_sec", 32'({sec1, sec0}), 32'h12);
      chk("rst_scores", 32'({score1, score2}), 0);
      chk("rst_winner", 32'(winner), 0);
      @(negedge clk); rst = 1'b0;

      // serve delay
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("serve_entry", 32'(state_o), 1);
      n = 0;
      while (stop === 1'b1 && n < 40) begin cyc(1'b0, 1'b0, 1'b0); n++; end
      chk("serve_delay", 32'(n), 32'(CLK_HZ));
      chk("play_sec", 32'({sec1, sec0}), 32'h12);

      // held miss2 scores once
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("miss_stop", 32'(stop), 1);
      chk("miss_score1", 32'(score1), 1);
      repeat (2) cyc(1'b0, 1'b0, 1'b1);
      chk("miss_once", 32'(score1), 1);
      wait_state(2, 40, n);
      chk("reserve_delay", 32'(n + 2), 32'(CLK_HZ));

      // countdown with BCD borrow
      repeat (30) cyc(1'b0, 1'b0, 1'b0);
      chk("borrow", 32'({sec1, sec0}), 32'h09);

      // three miss1 -> player 2 wins
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 1'b1, 1'b0);
         if (k < 2) wait_state(2, 40, n);
      end
      chk("win_score2", 32'(score2), 3);
      chk("win_state", 32'(state_o), 32'(ST_OVER));
      chk("win_winner", 32'(winner), 2);
      cyc(1'b0, 1'b1, 1'b0);
      chk("over_ignore", 32'(score2), 3);

      cyc(1'b1, 1'b0, 1'b0);
      chk("restart_state", 32'(state_o), 1);
      chk("restart_sec", 32'({sec1, sec0}), 32'h12);
      chk("restart_scores", 32'({score1, score2}), 0);
      chk("restart_winner", 32'(winner), 0);

      // timer expiry with a draw
      wait_state(2, 40, n);
      cyc(1'b0, 1'b1, 1'b0);
      wait_state(2, 40, n);
      cyc(1'b0, 1'b0, 1'b1);
      wait_state(2, 40, n);
      wait_state(ST_OVER, 200, n);
      chk("expire_len", 32'(n), 32'(GAME * CLK_HZ));
      chk("expire_sec", 32'({sec1, sec0}), 0);
      chk("expire_scores", 32'({score1, score2}), 32'h11);
      chk("expire_winner", 32'(winner), 3);
      cyc(1'b1, 1'b0, 1'b0);
      chk("restart2_sec", 32'({sec1, sec0}), 32'h12);
      chk("restart2_scores", 32'({score1, score2}), 0);
      chk("restart2_winner", 32'(winner), 0);

      // miss and tick on the same edge
      wait_state(2, 40, n);
      repeat (CLK_HZ - 1) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("coinc_sec", 32'({sec1, sec0}), 32'h11);
      chk("coinc_score2", 32'(score2), 1);
      chk("coinc_state", 32'(state_o), 1);

      // asynchronous reset mid-match
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_state", 32'(state_o), 0);
      chk("arst_stop", 32'(stop), 1);
      chk("arst_sec", 32'({sec1, sec0}), 32'h12);
      chk("arst_scores", 32'({score1, score2}), 0);
      model_reset();
      @(negedge clk); rst = 1'b0;

`ifdef PONG_PAUSE_EN
      cyc(1'b1, 1'b0, 1'b0);
      wait_state(2, 40, n);
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("pause_state", 32'(state_o), 32'(ST_PAUSE));
      chk("pause_stop", 32'(stop), 1);
      for (int k = 0; k < 50; k++) cyc(1'b0, k[2], k[3]);
      chk("pause_frozen", 32'({sec1, sec0}), 32'h12);
      chk("pause_scores", 32'({score1, score2}), 0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("resume_state", 32'(state_o), 2);
      n = 0;
      while ({sec1, sec0} == 8'h12 && n < 40) begin cyc(1'b0, 1'b0, 1'b0); n++; end
      chk("resume_rem", 32'(n), 32'(CLK_HZ - 4));
`endif

      // random play against the model
      for (int i = 0; i < 2000; i++)
         cyc($urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
